// File: rtl/addr_byte_exec.sv
// rtl/addr_byte_exec.sv - I2C address-phase executor: START, address bits, R/W bit, ACK sample
//
// Ports:
//   clock, rst_n          system clock, synchronous active-low reset
//   exec_addr             level request; a rising edge starts one address phase
//   address_curr          slave address, index 0 = MSB, sent first
//   curr_wr_or_rd         1 = write (R/W bit 0), 0 = read (R/W bit 1)
//   proc_id_in            process id, latched at start
//   exec_addr_finish      one-cycle pulse at the end of the phase
//   slaver_ack_ok         result pulse: slave ACKed
//   slaver_nack           result pulse: NACK or timeout
//   ack_timeout           result pulse: timeout only
//   tras_cmd_vld/_ready   command handshake towards the bit tap
//   tras_cmd              START=1, CMD_1=2, CMD_0=3, ACK=5
//   tras_cmd_mid          constant MODULE_ID
//   tras_cmd_proc_id      proc id latched at start
//   ack_vld, ack_bit      sampled ACK from the tap (0 = ACK)
module addr_byte_exec #(
  parameter int ALEN      = 7,
  parameter int CSIZE     = 4,
  parameter int MODULE_ID = 0,
  parameter int ACK_TMO   = 1023
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             exec_addr,
  input  logic [0:ALEN-1]  address_curr,
  input  logic             curr_wr_or_rd,
  input  logic [1:0]       proc_id_in,
  output logic             exec_addr_finish,
  output logic             slaver_ack_ok,
  output logic             slaver_nack,
  output logic             ack_timeout,
  output logic             tras_cmd_vld,
  output logic [CSIZE-1:0] tras_cmd,
  input  logic             tras_cmd_ready,
  output logic [3:0]       tras_cmd_mid,
  output logic [1:0]       tras_cmd_proc_id,
  input  logic             ack_vld,
  input  logic             ack_bit
);

  localparam logic [CSIZE-1:0] CMD_START = CSIZE'(1);
  localparam logic [CSIZE-1:0] CMD_1     = CSIZE'(2);
  localparam logic [CSIZE-1:0] CMD_0     = CSIZE'(3);
  localparam logic [CSIZE-1:0] CMD_ACK   = CSIZE'(5);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_START    = 3'd1;
  localparam logic [2:0] S_BITS     = 3'd2;
  localparam logic [2:0] S_ACK      = 3'd3;
  localparam logic [2:0] S_WAIT_ACK = 3'd4;
  localparam logic [2:0] S_FINISH   = 3'd5;
  localparam logic [2:0] S_HOLD     = 3'd6;

  localparam int BCW = $clog2(ALEN + 1);

  logic [2:0]     state;
  logic [ALEN:0]  shift;
  logic [BCW-1:0] bit_cnt;
  logic [15:0]    tmo_cnt;
  logic [15:0]    tmo_next;
  logic           tmo_hit;
  logic           exec_addr_q;
  logic           accept;

  assign tras_cmd_mid = 4'(MODULE_ID);
  assign accept       = tras_cmd_vld && tras_cmd_ready;
  assign tmo_next     = (tmo_cnt == 16'hFFFF) ? tmo_cnt : tmo_cnt + 16'd1;
  assign tmo_hit      = (tmo_next >= 16'(ACK_TMO));

  // Keeps sampling through reset so a request held high across reset
  // is not mistaken for a fresh rising edge after release.
  always_ff @(posedge clock) begin
    exec_addr_q <= exec_addr;
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      shift            <= '0;
      bit_cnt          <= '0;
      tmo_cnt          <= '0;
      tras_cmd_vld     <= 1'b0;
      tras_cmd         <= '0;
      tras_cmd_proc_id <= '0;
      exec_addr_finish <= 1'b0;
      slaver_ack_ok    <= 1'b0;
      slaver_nack      <= 1'b0;
      ack_timeout      <= 1'b0;
    end else begin
      exec_addr_finish <= 1'b0;
      slaver_ack_ok    <= 1'b0;
      slaver_nack      <= 1'b0;
      ack_timeout      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (exec_addr && !exec_addr_q) begin
            shift            <= {address_curr, ~curr_wr_or_rd};
            tras_cmd_proc_id <= proc_id_in;
            bit_cnt          <= '0;
            state            <= S_START;
          end
        end
        S_START: begin
          // First cycle raises START; on accept the first bit is loaded
          // in the same edge so commands run back-to-back.
          if (!tras_cmd_vld) begin
            tras_cmd_vld <= 1'b1;
            tras_cmd     <= CMD_START;
          end else if (tras_cmd_ready) begin
            tras_cmd <= shift[ALEN] ? CMD_1 : CMD_0;
            state    <= S_BITS;
          end
        end
        S_BITS: begin
          if (accept) begin
            shift   <= {shift[ALEN-1:0], 1'b0};
            bit_cnt <= bit_cnt + BCW'(1);
            if (bit_cnt == BCW'(ALEN)) begin
              tras_cmd <= CMD_ACK;
              state    <= S_ACK;
            end else begin
              tras_cmd <= shift[ALEN-1] ? CMD_1 : CMD_0;
            end
          end
        end
        S_ACK: begin
          if (accept) begin
            tras_cmd_vld <= 1'b0;
            tmo_cnt      <= '0;
            state        <= S_WAIT_ACK;
          end
        end
        S_WAIT_ACK: begin
          tmo_cnt <= tmo_next;
          // A sampled ACK takes priority over a timeout in the same cycle.
          if (ack_vld) begin
            exec_addr_finish <= 1'b1;
            slaver_ack_ok    <= ~ack_bit;
            slaver_nack      <= ack_bit;
            state            <= S_FINISH;
          end else if (tmo_hit) begin
            exec_addr_finish <= 1'b1;
            slaver_nack      <= 1'b1;
            ack_timeout      <= 1'b1;
            state            <= S_FINISH;
          end
        end
        S_FINISH: begin
          state <= S_HOLD;
        end
        S_HOLD: begin
          if (!exec_addr) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addr_byte_exec.sv
// tb/tb_addr_byte_exec.sv - directed self-checking bench for addr_byte_exec
module tb_addr_byte_exec;

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic       exec_addr = 1'b0;
  logic [0:6] address_curr = '0;
  logic       curr_wr_or_rd = 1'b0;
  logic [1:0] proc_id_in = '0;
  logic       exec_addr_finish, slaver_ack_ok, slaver_nack, ack_timeout;
  logic       tras_cmd_vld;
  logic [3:0] tras_cmd;
  logic       tras_cmd_ready = 1'b0;
  logic [3:0] tras_cmd_mid;
  logic [1:0] tras_cmd_proc_id;
  logic       ack_vld = 1'b0;
  logic       ack_bit = 1'b0;

  int total = 0;
  int bad   = 0;
  logic [3:0] got [0:15];
  int got_n = 0;

  addr_byte_exec #(.ALEN(7), .CSIZE(4), .MODULE_ID(5), .ACK_TMO(20)) dut (
    .clock(clock), .rst_n(rst_n), .exec_addr(exec_addr),
    .address_curr(address_curr), .curr_wr_or_rd(curr_wr_or_rd),
    .proc_id_in(proc_id_in), .exec_addr_finish(exec_addr_finish),
    .slaver_ack_ok(slaver_ack_ok), .slaver_nack(slaver_nack),
    .ack_timeout(ack_timeout), .tras_cmd_vld(tras_cmd_vld),
    .tras_cmd(tras_cmd), .tras_cmd_ready(tras_cmd_ready),
    .tras_cmd_mid(tras_cmd_mid), .tras_cmd_proc_id(tras_cmd_proc_id),
    .ack_vld(ack_vld), .ack_bit(ack_bit)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drops the request for one cycle, raises it, then checks start latency
  // and that inputs changed after the start edge are not picked up.
  task automatic start_phase(input logic [6:0] addr, input logic wr, input logic [1:0] pid);
    exec_addr = 1'b0;
    step();
    address_curr  = addr;
    curr_wr_or_rd = wr;
    proc_id_in    = pid;
    exec_addr     = 1'b1;
    step();
    check("start_lat_vld0", tras_cmd_vld, 0);
    address_curr  = ~addr;
    curr_wr_or_rd = ~wr;
    proc_id_in    = ~pid;
    step();
    check("start_cmd", {tras_cmd_vld, tras_cmd}, {1'b1, 4'd1});
    check("proc_id", tras_cmd_proc_id, pid);
  endtask

  task automatic collect(input int stall_max, input int n);
    int stall_left = 0;
    logic held = 1'b0;
    logic [3:0] held_cmd = '0;
    int guard = 0;
    got_n = 0;
    while (got_n < n && guard < 500) begin
      if (held) check("stall_hold", {tras_cmd_vld, tras_cmd}, {1'b1, held_cmd});
      held = 1'b0;
      if (tras_cmd_vld) begin
        if (stall_left == 0) begin
          tras_cmd_ready = 1'b1;
          got[got_n] = tras_cmd;
          got_n++;
          stall_left = $urandom_range(0, stall_max);
        end else begin
          tras_cmd_ready = 1'b0;
          stall_left--;
          held = 1'b1;
          held_cmd = tras_cmd;
        end
      end else begin
        tras_cmd_ready = 1'b0;
      end
      step();
      guard++;
    end
    tras_cmd_ready = 1'b0;
    check("collect_count", got_n, n);
    if (stall_max == 0) check("no_bubble", guard, n);
  endtask

  task automatic compare_seq(input string tag, input logic [39:0] expv, input int n);
    for (int i = 0; i < n; i++)
      check($sformatf("%s[%0d]", tag, i), got[i], expv[39-4*i -: 4]);
  endtask

  task automatic wait_finish(input int exp_cyc, input logic eok, input logic enack, input logic etmo);
    int cyc = 0;
    do begin
      step();
      cyc++;
      ack_vld = 1'b0;
    end while (!exec_addr_finish && cyc < 200);
    check("fin_cycles", cyc, exp_cyc);
    check("fin_flags", {exec_addr_finish, slaver_ack_ok, slaver_nack, ack_timeout},
          {1'b1, eok, enack, etmo});
    check("fin_vld_low", tras_cmd_vld, 0);
    step();
    check("fin_pulse_len", {exec_addr_finish, slaver_ack_ok, slaver_nack, ack_timeout}, 0);
  endtask

  initial begin
    logic seen;

    repeat (3) step();
    check("rst_vld_cmd", {tras_cmd_vld, tras_cmd, tras_cmd_proc_id}, 0);
    check("rst_pulses", {exec_addr_finish, slaver_ack_ok, slaver_nack, ack_timeout}, 0);
    check("mid_const", tras_cmd_mid, 5);
    rst_n = 1'b1;
    step();

    // Write to 0x50, ready tied, slave ACKs; request then held high.
    start_phase(7'h50, 1'b1, 2'd2);
    collect(0, 10);
    compare_seq("seq_w50", 40'h1232333335, 10);
    ack_bit = 1'b0;
    ack_vld = 1'b1;
    wait_finish(1, 1'b1, 1'b0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      seen = seen | tras_cmd_vld | exec_addr_finish;
    end
    check("hold_no_restart", seen, 0);

    // Read from 0x3C, re-raised request, slave NACKs.
    start_phase(7'h3C, 1'b0, 2'd1);
    collect(0, 10);
    compare_seq("seq_r3c", 40'h1322223325, 10);
    ack_bit = 1'b1;
    ack_vld = 1'b1;
    wait_finish(1, 1'b0, 1'b1, 1'b0);

    // Read from 0x2A with random ready stalls; a stray ack_vld during the
    // command phase must be ignored.
    start_phase(7'h2A, 1'b0, 2'd3);
    ack_bit = 1'b0;
    ack_vld = 1'b1;
    collect(5, 10);
    ack_vld = 1'b0;
    compare_seq("seq_r2a_stall", 40'h1323232325, 10);
    step();
    step();
    check("no_early_finish", exec_addr_finish, 0);
    ack_bit = 1'b1;
    ack_vld = 1'b1;
    wait_finish(1, 1'b0, 1'b1, 1'b0);

    // Timeout: no ack_vld, finish 20 cycles after the ACK accept.
    start_phase(7'h01, 1'b1, 2'd0);
    collect(0, 10);
    compare_seq("seq_w01", 40'h1333333235, 10);
    wait_finish(20, 1'b0, 1'b1, 1'b1);

    // ack_vld on the limit cycle wins over the timeout.
    start_phase(7'h01, 1'b1, 2'd0);
    collect(0, 10);
    seen = 1'b0;
    for (int i = 0; i < 19; i++) begin
      step();
      seen = seen | exec_addr_finish;
    end
    check("limit_no_early", seen, 0);
    ack_bit = 1'b0;
    ack_vld = 1'b1;
    wait_finish(1, 1'b1, 1'b0, 1'b0);

    // Reset during BITS with the request held high.
    start_phase(7'h50, 1'b1, 2'd2);
    collect(0, 4);
    compare_seq("seq_pre_rst", 40'h1232000000, 4);
    rst_n = 1'b0;
    step();
    check("rst_mid_vld", {tras_cmd_vld, exec_addr_finish}, 0);
    step();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      seen = seen | tras_cmd_vld | exec_addr_finish;
    end
    check("rst_stay_idle", seen, 0);

    // Fresh phase after reset: read from 0x00, ACK.
    start_phase(7'h00, 1'b0, 2'd1);
    collect(0, 10);
    compare_seq("seq_r00", 40'h1333333325, 10);
    ack_bit = 1'b0;
    ack_vld = 1'b1;
    wait_finish(1, 1'b1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/addr_byte_exec.md
# addr_byte_exec

Address-phase executor of the I2C byte-stage controller. Started by the main status controller's `exec_addr` request, it emits START, the ALEN address bits (MSB first) and the R/W bit as serial bit commands on the tras command port. It then issues an ACK-sample command and returns `exec_addr_finish` with the slave ACK/NACK result.

## Interface
- ALEN, 7, address width in bits.
- CSIZE, 4, tras command width.
- MODULE_ID, 0, value driven on `tras_cmd_mid`.
- ACK_TMO, 1023, cycles to wait for `ack_vld` before declaring timeout; 1..65535.

- clock  in  1  system clock, all logic on rising edge.
- rst_n  in  1  reset: synchronous, active-low.
- exec_addr  in  1  level request from the main controller; a rising edge starts one address phase.
- address_curr  in  [0:ALEN-1]  slave address; index 0 is the MSB and is sent first.
- curr_wr_or_rd  in  1  1 = write (R/W bit 0), 0 = read (R/W bit 1).
- proc_id_in  in  2  process id from the main controller; latched at start.
- exec_addr_finish  out  1  one-cycle pulse when the phase ends.
- slaver_ack_ok  out  1  one-cycle pulse coincident with finish when the slave ACKed.
- slaver_nack  out  1  one-cycle pulse coincident with finish on NACK or timeout.
- ack_timeout  out  1  one-cycle pulse coincident with finish on timeout only.
- tras_cmd_vld  out  1  command valid.
- tras_cmd  out  CSIZE  command code: START=1, CMD_1=2, CMD_0=3, ACK=5.
- tras_cmd_ready  in  1  tap accepts the command.
- tras_cmd_mid  out  4  constant MODULE_ID.
- tras_cmd_proc_id  out  2  proc id latched at start.
- ack_vld  in  1  tap has sampled the ACK bit.
- ack_bit  in  1  sampled SDA: 0 = ACK, 1 = NACK.

## Operation
- States: IDLE, START, BITS, ACK, WAIT_ACK, FINISH, HOLD.
- **IDLE**
  - On the `exec_addr` rising edge (registered `exec_addr` low the previous cycle), latch shift register `{address_curr[0:ALEN-1], ~curr_wr_or_rd}` (ALEN+1 bits) and `proc_id_in`.
  - Clear `bit_cnt`; go to START.
- **START**
  - Present START.
  - On `vld && ready`, go to BITS.
- **BITS**
  - Present CMD_1 if the shift MSB is 1, else CMD_0.
  - On accept: shift left and increment `bit_cnt`.
  - After the accept with `bit_cnt == ALEN` (ALEN+1 bits sent), go to ACK.
- **ACK**
  - Present ACK.
  - On accept, clear the timeout counter and go to WAIT_ACK.
- **WAIT_ACK**
  - `ack_vld` with `ack_bit == 0` → FINISH with result ACK.
  - `ack_vld` with `ack_bit == 1` → FINISH with result NACK.
  - Counter reaching ACK_TMO → FINISH with result timeout.
  - `ack_vld` and timeout in the same cycle: `ack_vld` wins.
- **FINISH**
  - Pulse `exec_addr_finish` plus the matching result pulse.
  - Go to HOLD.
- **HOLD**
  - Wait for `exec_addr == 0`, then go to IDLE.
  - This prevents a still-high level request from restarting the phase.
- `ack_vld` outside WAIT_ACK is ignored.
- `exec_addr` falling mid-phase is ignored; the sequence runs to FINISH.
- The address and R/W inputs are sampled only at start; later changes have no effect.

## Timing
- Reset values:
  - `tras_cmd_vld` = 0, `tras_cmd` = 0, `tras_cmd_proc_id` = 0.
  - All pulses = 0.
  - State = IDLE, `bit_cnt` = 0, timeout counter = 0.
- Reset asserted mid-phase: `tras_cmd_vld` and the pulses go to 0 at the next edge; no finish is issued.
- All outputs are registered except `tras_cmd_mid`.
- Start latency: `exec_addr` first sampled high at edge T → `tras_cmd_vld = 1` with START from edge T+1.
- Handshake:
  - `tras_cmd_vld` and `tras_cmd` stay stable until `tras_cmd_ready`.
  - Back-to-back commands are allowed: after an accept at edge N, the next command is valid from edge N (no bubble).
  - `vld` never drops without an accept, except on reset.
- `tras_cmd_vld` is 0 during WAIT_ACK, FINISH, HOLD and IDLE.
- Latency with `ready` tied to 1: 10 commands for ALEN = 7; `ack_vld` at cycle K → `exec_addr_finish` at edge K+1.
- Timeout counter: 16 bits, saturating, increments once per WAIT_ACK cycle.

## Test plan
- Write to 7'h50 with `ready` = 1: cmd sequence 1,2,3,2,3,3,3,3,3,5; `ack_bit` = 0 → `exec_addr_finish` and `slaver_ack_ok` pulse together for 1 cycle, `slaver_nack` = 0.
- Read from 7'h3C: sequence 1,3,2,2,2,2,3,3,2,5; `ack_bit` = 1 → finish with `slaver_nack` = 1, `slaver_ack_ok` = 0.
- Random `tras_cmd_ready` stalls (0–5 cycles): `tras_cmd` stays constant while `vld && !ready`; no command is lost or duplicated.
- No `ack_vld`, ACK_TMO = 20: finish with `slaver_nack` = 1 and `ack_timeout` = 1 exactly 20 cycles after the ACK accept; `ack_vld` arriving at the limit cycle → ACK result.
- `exec_addr` held high for 50 cycles after finish: no second START; dropping it and re-raising starts a new phase with the newly latched address.
- `rst_n` = 0 during BITS: `tras_cmd_vld` = 0 next cycle, no finish; after release, idle until a new `exec_addr` rising edge.
